// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and burst-length helper for the arbiter, interconnect and DMA master.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam int BEATS_W = 5;

  // Undefined-length INCR counts as one beat so it stays rearbitrable every beat.
  function automatic logic [BEATS_W-1:0] burst_len(input logic [2:0] hburst);
    case (hburst_e'(hburst))
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      default:                      burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Rotating-priority search: first set req bit after 'last', wrapping, ending at 'last'.
module ahb_arb_rr_pick #(
  parameter int NUM_M = 3,
  parameter int MW    = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [MW-1:0]    last,
  output logic             valid,
  output logic [MW-1:0]    win
);

  logic [MW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    win   = last;
    cand  = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = MW'((int'(last) + k) % NUM_M);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        win   = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB bus arbiter with burst-aware rearbitration points.
// Optional locked-transfer support is enabled with macro AHB_ARB_LOCK_EN.
module ahb_arbiter_rr
  import ahb_arb_pkg::*;
#(
  parameter int NUM_M     = 3,
  parameter int DEFAULT_M = 0,
  parameter int MW        = $clog2(NUM_M)
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NUM_M-1:0] HBUSREQ,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HBURST,
  input  logic             HREADY,
`ifdef AHB_ARB_LOCK_EN
  input  logic [NUM_M-1:0] HLOCK,
`endif
  output logic [NUM_M-1:0] HGRANT,
  output logic [MW-1:0]    HMASTER,
`ifdef AHB_ARB_LOCK_EN
  output logic             HMASTLOCK,
`endif
  output logic [MW-1:0]    HMASTER_D
);

  localparam logic [MW-1:0]    DEF_IDX   = MW'(DEFAULT_M);
  localparam logic [NUM_M-1:0] DEF_GRANT = NUM_M'(1) << DEFAULT_M;

  logic [MW-1:0]      grant_idx;
  logic [BEATS_W-1:0] beats_left;
  logic [BEATS_W-1:0] beats_nxt;
  logic               locked;
  logic               rearb;
  logic               pick_valid;
  logic [MW-1:0]      pick_win;
  logic [MW-1:0]      next_idx;

`ifdef AHB_ARB_LOCK_EN
  assign locked = HLOCK[grant_idx];
`else
  assign locked = 1'b0;
`endif

  // HREADY is the only bus-level handshake: every state update below happens
  // on an HREADY=1 edge, and wait states (HREADY=0) freeze everything.
  assign rearb = HREADY
               && ((beats_left == 5'd0) || ((beats_left == 5'd1) && (HTRANS == HTRANS_SEQ)))
               && (HTRANS != HTRANS_BUSY)
               && !locked;

  ahb_arb_rr_pick #(
    .NUM_M (NUM_M),
    .MW    (MW)
  ) u_pick (
    .req   (HBUSREQ),
    .last  (HMASTER),
    .valid (pick_valid),
    .win   (pick_win)
  );

  assign next_idx = pick_valid ? pick_win : DEF_IDX;

  always_comb begin
    beats_nxt = beats_left;
    case (htrans_e'(HTRANS))
      HTRANS_NONSEQ: beats_nxt = burst_len(HBURST) - 5'd1;
      HTRANS_SEQ:    if (beats_left != 5'd0) beats_nxt = beats_left - 5'd1;
      HTRANS_IDLE:   beats_nxt = 5'd0;
      default:       beats_nxt = beats_left;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_idx  <= DEF_IDX;
      HGRANT     <= DEF_GRANT;
      HMASTER    <= DEF_IDX;
      HMASTER_D  <= DEF_IDX;
      beats_left <= 5'd0;
    end else if (HREADY) begin
      HMASTER    <= grant_idx;
      HMASTER_D  <= HMASTER;
      beats_left <= beats_nxt;
      if (rearb) begin
        grant_idx <= next_idx;
        HGRANT    <= NUM_M'(1) << next_idx;
      end
    end
  end

`ifdef AHB_ARB_LOCK_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      HMASTLOCK <= locked;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Self-checking bench for ahb_arbiter_rr (NUM_M=3, DEFAULT_M=0) with a behavioural bus model.
module tb_ahb_arbiter_rr;

  localparam int NUM_M     = 3;
  localparam int DEFAULT_M = 0;
  localparam int MW        = 2;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [NUM_M-1:0] HBUSREQ;
  logic [1:0]       HTRANS;
  logic [2:0]       HBURST;
  logic             HREADY;
  logic [NUM_M-1:0] HGRANT;
  logic [MW-1:0]    HMASTER;
  logic [MW-1:0]    HMASTER_D;
`ifdef AHB_ARB_LOCK_EN
  logic [NUM_M-1:0] HLOCK;
  logic             HMASTLOCK;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: owner indices as integers, remaining beats as a plain count.
  int m_grant, m_master, m_master_d, m_beats;
  bit m_mlock;

  logic [MW-1:0] exp_q[$];

  always #5 HCLK = ~HCLK;

  ahb_arbiter_rr #(
    .NUM_M     (NUM_M),
    .DEFAULT_M (DEFAULT_M),
    .MW        (MW)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
`ifdef AHB_ARB_LOCK_EN
    .HLOCK     (HLOCK),
    .HMASTLOCK (HMASTLOCK),
`endif
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D)
  );

  task automatic model_reset();
    m_grant    = DEFAULT_M;
    m_master   = DEFAULT_M;
    m_master_d = DEFAULT_M;
    m_beats    = 0;
    m_mlock    = 1'b0;
  endtask

  task automatic model_edge();
    int len, w, c;
    bit rb, lk;
    if (HREADY) begin
      lk = 1'b0;
`ifdef AHB_ARB_LOCK_EN
      lk = ((HLOCK >> m_grant) & 3'd1) != 3'd0;
`endif
      rb = (m_beats == 0 || (m_beats == 1 && HTRANS == 2'd3)) && HTRANS != 2'd1 && !lk;
      // Scan the rotation backwards so the nearest requester after the owner is kept.
      w = DEFAULT_M;
      for (int k = NUM_M; k >= 1; k--) begin
        c = (m_master + k) % NUM_M;
        if (((HBUSREQ >> c) & 3'd1) != 3'd0) w = c;
      end
      len = (HBURST < 3'd2) ? 1 : (2 << (HBURST >> 1));
      m_master_d = m_master;
      m_master   = m_grant;
      m_mlock    = lk;
      if (HTRANS == 2'd2) m_beats = len - 1;
      else if (HTRANS == 2'd3 && m_beats > 0) m_beats = m_beats - 1;
      else if (HTRANS == 2'd0) m_beats = 0;
      if (rb) m_grant = w;
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    if (HRESETn) model_edge();
    @(negedge HCLK);
  endtask

  task automatic drive(input logic [1:0] t, input logic [2:0] b, input logic [2:0] r, input logic rdy);
    HTRANS  = t;
    HBURST  = b;
    HBUSREQ = r;
    HREADY  = rdy;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    drive(2'd0, 3'd0, 3'b000, 1'b1);
`ifdef AHB_ARB_LOCK_EN
    HLOCK = '0;
`endif
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive(2'd0, 3'd0, 3'b111, 1'b1);
`ifdef AHB_ARB_LOCK_EN
    HLOCK = '0;
`endif
    @(negedge HCLK);
    @(negedge HCLK);
    model_reset();
    checks++; if (HGRANT !== 3'b001) begin failures++; $display("FAIL reset_hgrant: got %b expected 001", HGRANT); end
    checks++; if (HMASTER !== 2'd0) begin failures++; $display("FAIL reset_hmaster: got %0d expected 0", HMASTER); end
    checks++; if (HMASTER_D !== 2'd0) begin failures++; $display("FAIL reset_hmaster_d: got %0d expected 0", HMASTER_D); end
`ifdef AHB_ARB_LOCK_EN
    checks++; if (HMASTLOCK !== 1'b0) begin failures++; $display("FAIL reset_hmastlock: got %b expected 0", HMASTLOCK); end
`endif
  endtask

  task automatic test_first_arb();
    HRESETn = 1'b1;
    drive(2'd0, 3'd0, 3'b111, 1'b0);
    tick();
    checks++; if (HGRANT !== 3'b001) begin failures++; $display("FAIL first_arb_wait: got %b expected 001", HGRANT); end
    HREADY = 1'b1;
    tick();
    checks++; if (HGRANT !== 3'b010) begin failures++; $display("FAIL first_arb_grant: got %b expected 010", HGRANT); end
    checks++; if (HMASTER !== 2'd0) begin failures++; $display("FAIL first_arb_hmaster: got %0d expected 0", HMASTER); end
  endtask

  task automatic test_incr4_handover();
    logic [2:0] exp_g;
    do_reset();
    // Master 0 still requests at the NONSEQ edge, which is itself an arbitration point.
    drive(2'd2, 3'd3, 3'b001, 1'b1);
    tick();
    checks++; if (HGRANT !== 3'b001) begin failures++; $display("FAIL incr4_nonseq: got %b expected 001", HGRANT); end
    for (int b = 1; b <= 3; b++) begin
      drive(2'd3, 3'd3, 3'b110, 1'b1);
      tick();
      exp_g = (b == 3) ? 3'b010 : 3'b001;
      checks++; if (HGRANT !== exp_g) begin failures++; $display("FAIL incr4_seq%0d: got %b expected %b", b, HGRANT, exp_g); end
    end
    drive(2'd0, 3'd0, 3'b110, 1'b1);
    tick();
    checks++; if (HMASTER !== 2'd1) begin failures++; $display("FAIL incr4_hmaster: got %0d expected 1", HMASTER); end
    checks++; if (HMASTER_D !== 2'd0) begin failures++; $display("FAIL incr4_hmaster_d: got %0d expected 0", HMASTER_D); end
  endtask

  task automatic test_round_robin();
    int prev, obs, popped;
    logic [2:0] exp_g;
    do_reset();
    exp_q = {2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    prev = DEFAULT_M;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
      drive(2'd2, 3'd0, 3'b111, 1'b1);
      tick();
      exp_g = 3'b001 << m_grant;
      checks++; if (HGRANT !== exp_g) begin failures++; $display("FAIL rr_model: got %b expected %b", HGRANT, exp_g); end
      case (HGRANT)
        3'b001:  obs = 0;
        3'b010:  obs = 1;
        3'b100:  obs = 2;
        default: obs = -1;
      endcase
      if (obs != prev) begin
        popped = int'(exp_q.pop_front());
        checks++; if (obs != popped) begin failures++; $display("FAIL rr_sequence: got %0d expected %0d", obs, popped); end
        prev = obs;
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr_timeout: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_wait_states();
    int handover;
    handover = 0;
    do_reset();
    for (int t = 1; t <= 20 && handover == 0; t++) begin
      if (t == 1)      drive(2'd2, 3'd5, 3'b001, 1'b1);
      else if (t <= 4) drive(2'd3, 3'd5, 3'b010, 1'b1);
      else if (t <= 7) drive(2'd3, 3'd5, 3'b100, 1'b0);
      else             drive(2'd3, 3'd5, 3'b010, 1'b1);
      tick();
      if (t >= 5 && t <= 7) begin
        checks++; if (HGRANT !== 3'b001) begin failures++; $display("FAIL wait_hgrant t%0d: got %b expected 001", t, HGRANT); end
        checks++; if (HMASTER !== 2'd0 || HMASTER_D !== 2'd0) begin
          failures++; $display("FAIL wait_hmaster t%0d: got %0d/%0d expected 0/0", t, HMASTER, HMASTER_D);
        end
      end
      if (HGRANT === 3'b010) handover = t;
    end
    checks++; if (handover != 11) begin failures++; $display("FAIL wait_handover: got cycle %0d expected 11", handover); end
    drive(2'd0, 3'd0, 3'b000, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(2'd0, 3'd0, 3'b100, 1'b1);
    tick();
    tick();
    checks++; if (HMASTER !== 2'd2) begin failures++; $display("FAIL mid_reset_owner: got %0d expected 2", HMASTER); end
    drive(2'd2, 3'd7, 3'b100, 1'b1);
    tick();
    for (int b = 2; b <= 4; b++) begin
      drive(2'd3, 3'd7, 3'b100, 1'b1);
      tick();
    end
    checks++; if (HGRANT !== 3'b100) begin failures++; $display("FAIL mid_reset_pre: got %b expected 100", HGRANT); end
    drive(2'd3, 3'd7, 3'b011, 1'b1);
    @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    checks++; if (HGRANT !== 3'b001) begin failures++; $display("FAIL mid_reset_hgrant: got %b expected 001", HGRANT); end
    checks++; if (HMASTER !== 2'd0 || HMASTER_D !== 2'd0) begin
      failures++; $display("FAIL mid_reset_hmaster: got %0d/%0d expected 0/0", HMASTER, HMASTER_D);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(2'd0, 3'd0, 3'b000, 1'b1);
    model_reset();
  endtask

`ifdef AHB_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    drive(2'd0, 3'd0, 3'b010, 1'b1);
    tick();
    tick();
    HLOCK = 3'b010;
    for (int n = 0; n < 8; n++) begin
      drive((n % 4 == 0) ? 2'd2 : 2'd3, 3'd3, 3'b111, 1'b1);
      tick();
      checks++; if (HGRANT !== 3'b010) begin failures++; $display("FAIL lock_hold beat%0d: got %b expected 010", n, HGRANT); end
      checks++; if (HMASTLOCK !== 1'b1) begin failures++; $display("FAIL lock_hmastlock beat%0d: got %b expected 1", n, HMASTLOCK); end
    end
    HLOCK = 3'b000;
    drive(2'd0, 3'd0, 3'b111, 1'b1);
    tick();
    checks++; if (HGRANT !== 3'b100) begin failures++; $display("FAIL lock_release: got %b expected 100", HGRANT); end
  endtask
`endif

  task automatic test_random();
    logic [2:0] exp_g;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0));
`ifdef AHB_ARB_LOCK_EN
      HLOCK = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
`endif
      tick();
      exp_g = 3'b001 << m_grant;
      checks++; if (HGRANT !== exp_g) begin failures++; $display("FAIL rand_hgrant i%0d: got %b expected %b", i, HGRANT, exp_g); end
      checks++; if (HMASTER !== 2'(m_master)) begin failures++; $display("FAIL rand_hmaster i%0d: got %0d expected %0d", i, HMASTER, m_master); end
      checks++; if (HMASTER_D !== 2'(m_master_d)) begin failures++; $display("FAIL rand_hmaster_d i%0d: got %0d expected %0d", i, HMASTER_D, m_master_d); end
      checks++; if (!$onehot(HGRANT)) begin failures++; $display("FAIL rand_onehot i%0d: got %b expected one-hot", i, HGRANT); end
`ifdef AHB_ARB_LOCK_EN
      checks++; if (HMASTLOCK !== m_mlock) begin failures++; $display("FAIL rand_hmastlock i%0d: got %b expected %b", i, HMASTLOCK, m_mlock); end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_first_arb();
    test_incr4_handover();
    test_round_robin();
    test_wait_states();
    test_reset_mid_burst();
`ifdef AHB_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
